// File: rtl/mdio_pkg.sv
// Shared constants, field positions and state encoding
// for the Clause-22 MDIO master.
package mdio_pkg;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int WORD_MSB = 31;
    localparam int OP_HI    = 29;
    localparam int OP_LO    = 28;

    localparam logic [5:0] FRAME_BITS  = 6'd32;
    localparam logic [5:0] RD_HDR_BITS = 6'd14;
    localparam logic [5:0] READ_SLOTS  = 6'd18;
    localparam logic [5:0] TA_SLOTS    = 6'd2;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        FRAME_OUT,
        READ_IN,
        DONE
    } state_t;

    function automatic logic op_ok(
        input logic [31:0] w
    );
        return (w[OP_HI:OP_LO] == OP_WRITE) ||
               (w[OP_HI:OP_LO] == OP_READ);
    endfunction

    function automatic logic op_is_read(
        input logic [31:0] w
    );
        return w[OP_HI:OP_LO] == OP_READ;
    endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: one low phase then one high phase per slot,
// with strobes for the edges that start each phase.
module mdc_gen #(
    parameter int MDC_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic mdc_fall,
    output logic mdc_rise
);

    localparam int CW = $clog2(MDC_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(MDC_DIV - 1);

    logic [CW-1:0] div;
    logic          started;

    // First slot starts on the clk right after enable.
    assign mdc_fall = en &&
        (!started || (mdc && div == LAST));
    assign mdc_rise = en && started &&
        !mdc && div == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            mdc     <= 1'b0;
            started <= 1'b0;
        end else if (!en) begin
            div     <= '0;
            mdc     <= 1'b0;
            started <= 1'b0;
        end else if (mdc_fall) begin
            div     <= '0;
            mdc     <= 1'b0;
            started <= 1'b1;
        end else if (mdc_rise) begin
            div <= '0;
            mdc <= 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO master: one read or write frame per
// accepted request, preamble first, MDC from clk.
module mdio_master_ctrl
    import mdio_pkg::*;
#(
    parameter int MDC_DIV      = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic        BUSY,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY
);

    localparam state_t START_ST =
        (PREAMBLE_LEN == 0) ? FRAME_OUT : PREAMBLE;

    state_t      state, state_n;
    state_t      seg;
    logic [5:0]  slot, slot_n, seg_slot, seg_len;
    logic [31:0] shreg, shreg_n;
    logic [15:0] rx, rx_n;
    logic [15:0] rd_n;
    logic        is_read, is_read_n;
    logic        out_n, oe_n, busy_n, rdy_n;
    logic        fall, rise;

    mdc_gen #(
        .MDC_DIV (MDC_DIV)
    ) u_mdc (
        .clk      (clk),
        .rst_n    (reset),
        .en       (BUSY),
        .mdc      (MDC),
        .mdc_fall (fall),
        .mdc_rise (rise)
    );

    always_comb begin
        seg_len = 6'd0;
        unique case (state)
            PREAMBLE:  seg_len = 6'(PREAMBLE_LEN);
            FRAME_OUT: seg_len = is_read ?
                RD_HDR_BITS : FRAME_BITS;
            READ_IN:   seg_len = READ_SLOTS;
            default:   seg_len = 6'd0;
        endcase
    end

    // A segment that has used all its slots hands the
    // starting slot edge over to the following segment.
    always_comb begin
        seg      = state;
        seg_slot = slot;
        if (fall && slot == seg_len) begin
            seg_slot = 6'd0;
            unique case (state)
                PREAMBLE:  seg = FRAME_OUT;
                FRAME_OUT: seg = is_read ? READ_IN : DONE;
                READ_IN:   seg = DONE;
                default:   seg = state;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        slot_n    = slot;
        shreg_n   = shreg;
        rx_n      = rx;
        is_read_n = is_read;
        out_n     = MDIO_OUT;
        oe_n      = MDIO_OE;
        busy_n    = BUSY;
        rd_n      = RD_DATA;
        rdy_n     = 1'b0;
        unique case (seg)
            IDLE: begin
                if (MDIO_START && op_ok(T_DATA)) begin
                    state_n   = START_ST;
                    slot_n    = 6'd0;
                    shreg_n   = T_DATA;
                    rx_n      = 16'd0;
                    is_read_n = op_is_read(T_DATA);
                    busy_n    = 1'b1;
                end
            end
            PREAMBLE: begin
                if (fall) begin
                    state_n = seg;
                    slot_n  = seg_slot + 6'd1;
                    out_n   = 1'b1;
                    oe_n    = 1'b1;
                end
            end
            FRAME_OUT: begin
                if (fall) begin
                    state_n = seg;
                    slot_n  = seg_slot + 6'd1;
                    out_n   = shreg[WORD_MSB];
                    oe_n    = 1'b1;
                    shreg_n = {shreg[30:0], 1'b0};
                end
            end
            READ_IN: begin
                if (fall) begin
                    state_n = seg;
                    slot_n  = seg_slot + 6'd1;
                    out_n   = 1'b0;
                    oe_n    = 1'b0;
                end
                // slot holds index+1; TA slots are skipped
                if (rise && slot > TA_SLOTS)
                    rx_n = {rx[14:0], MDIO_IN};
            end
            DONE: begin
                if (state == DONE) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                    slot_n  = 6'd0;
                    out_n   = 1'b0;
                    oe_n    = 1'b0;
                    busy_n  = 1'b0;
                    if (is_read) begin
                        rd_n  = rx;
                        rdy_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            slot     <= 6'd0;
            shreg    <= 32'd0;
            rx       <= 16'd0;
            is_read  <= 1'b0;
            MDIO_OUT <= 1'b0;
            MDIO_OE  <= 1'b0;
            BUSY     <= 1'b0;
            RD_DATA  <= 16'd0;
            DATA_RDY <= 1'b0;
        end else begin
            state    <= state_n;
            slot     <= slot_n;
            shreg    <= shreg_n;
            rx       <= rx_n;
            is_read  <= is_read_n;
            MDIO_OUT <= out_n;
            MDIO_OE  <= oe_n;
            BUSY     <= busy_n;
            RD_DATA  <= rd_n;
            DATA_RDY <= rdy_n;
        end
    end

endmodule
